rob_mdp_update_receiver: RTL and testbench

- Receiving end of the store-set unit's ROB memory-dependence-predictor update interface (rob_mdp_update_*).
- The store-set unit has no backpressure, so this block accepts every update pulse and buffers it in a small circular queue.
- Repeated updates to the same ROB entry are coalesced.
- Entries are drained through a valid/ready write port into the ROB mdp_info array; entries squashed by a ROB kill are discarded.

---
 rtl/rob_mdp_update_receiver.sv | 137 +++++++++++++
 tb/tb_rob_mdp_update_receiver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_mdp_update_receiver.sv
// Receiver for store-set MDP updates. Buffers updates in a small coalescing circular queue
// and drains them into the ROB mdp_info array, discarding entries squashed by a ROB kill.
module rob_mdp_update_receiver #(
   parameter int unsigned ROB_ENTRIES       = 128,
   parameter int unsigned LOG_ROB_ENTRIES   = $clog2(ROB_ENTRIES),
   parameter int unsigned MDPT_INFO_WIDTH   = 8,
   parameter int unsigned RX_BUFFER_ENTRIES = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       rob_mdp_update_valid,
   input  logic [MDPT_INFO_WIDTH-1:0] rob_mdp_update_mdp_info,
   input  logic [LOG_ROB_ENTRIES-1:0] rob_mdp_update_ROB_index,
   input  logic [LOG_ROB_ENTRIES-1:0] rob_head_index,
   input  logic                       rob_kill_valid,
   input  logic [LOG_ROB_ENTRIES-1:0] rob_kill_start_ROB_index,
   output logic                       rob_mdp_write_valid,
   output logic [MDPT_INFO_WIDTH-1:0] rob_mdp_write_mdp_info,
   output logic [LOG_ROB_ENTRIES-1:0] rob_mdp_write_ROB_index,
   input  logic                       rob_mdp_write_ready,
   output logic                       drop_pulse,
   output logic [7:0]                 drop_count
);

   localparam int unsigned PTR_W = $clog2(RX_BUFFER_ENTRIES);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RX_BUFFER_ENTRIES);

   logic [RX_BUFFER_ENTRIES-1:0] v_q, v_d;
   logic [LOG_ROB_ENTRIES-1:0]   idx_q  [RX_BUFFER_ENTRIES];
   logic [LOG_ROB_ENTRIES-1:0]   idx_d  [RX_BUFFER_ENTRIES];
   logic [MDPT_INFO_WIDTH-1:0]   info_q [RX_BUFFER_ENTRIES];
   logic [MDPT_INFO_WIDTH-1:0]   info_d [RX_BUFFER_ENTRIES];
   logic [PTR_W-1:0]             head_q, head_d, tail_q, tail_d, merge_ptr;
   logic [CNT_W-1:0]             occ_q, occ_d;
   logic                         drop_pulse_q, drop_pulse_d;
   logic [7:0]                   drop_count_q, drop_count_d;
   logic                         not_empty, head_v, head_killed, pop;
   logic                         upd_live, merge_hit, enq, drop;

   // Killed when the index is at least as young as the kill start, ages taken from the ROB head.
   function automatic logic is_killed(input logic                       kv,
                                      input logic [LOG_ROB_ENTRIES-1:0] x,
                                      input logic [LOG_ROB_ENTRIES-1:0] start,
                                      input logic [LOG_ROB_ENTRIES-1:0] head);
      logic [LOG_ROB_ENTRIES-1:0] age_x, age_k;
      age_x = x - head;
      age_k = start - head;
      return kv && (age_x >= age_k);
   endfunction

   always_comb begin
      not_empty   = (occ_q != '0);
      head_v      = v_q[head_q];
      head_killed = is_killed(rob_kill_valid, idx_q[head_q], rob_kill_start_ROB_index,
                              rob_head_index);

      rob_mdp_write_valid     = ~RST & not_empty & head_v & ~head_killed;
      rob_mdp_write_mdp_info  = info_q[head_q];
      rob_mdp_write_ROB_index = idx_q[head_q];

      // Holes (invalidated or killed heads) drain without a write.
      pop = not_empty & ((rob_mdp_write_valid & rob_mdp_write_ready) | ~head_v | head_killed);

      upd_live = rob_mdp_update_valid &
                 ~is_killed(rob_kill_valid, rob_mdp_update_ROB_index, rob_kill_start_ROB_index,
                            rob_head_index);

      merge_hit = 1'b0;
      merge_ptr = '0;
      for (int i = 0; i < int'(RX_BUFFER_ENTRIES); i++) begin
         if (v_q[i] && (idx_q[i] == rob_mdp_update_ROB_index) &&
             !(pop && (PTR_W'(i) == head_q))) begin
            merge_hit = 1'b1;
            merge_ptr = PTR_W'(i);
         end
      end

      enq  = upd_live & ~merge_hit & ((occ_q != FULL_CNT) | pop);
      drop = upd_live & ~merge_hit & ~enq;

      v_d    = v_q;
      idx_d  = idx_q;
      info_d = info_q;
      for (int i = 0; i < int'(RX_BUFFER_ENTRIES); i++) begin
         if (is_killed(rob_kill_valid, idx_q[i], rob_kill_start_ROB_index, rob_head_index)) begin
            v_d[i] = 1'b0;
         end
      end
      if (pop) begin
         v_d[head_q] = 1'b0;
      end
      if (upd_live && merge_hit) begin
         info_d[merge_ptr] = rob_mdp_update_mdp_info;
      end
      // Applied after the pop clear: on a full queue with a pop, tail aliases head.
      if (enq) begin
         v_d[tail_q]    = 1'b1;
         idx_d[tail_q]  = rob_mdp_update_ROB_index;
         info_d[tail_q] = rob_mdp_update_mdp_info;
      end

      head_d       = pop ? head_q + PTR_W'(1) : head_q;
      tail_d       = enq ? tail_q + PTR_W'(1) : tail_q;
      occ_d        = occ_q + CNT_W'(enq) - CNT_W'(pop);
      drop_pulse_d = drop;
      drop_count_d = (drop && (drop_count_q != 8'hFF)) ? drop_count_q + 8'd1 : drop_count_q;

      drop_pulse = drop_pulse_q;
      drop_count = drop_count_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         v_q          <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         occ_q        <= '0;
         drop_pulse_q <= 1'b0;
         drop_count_q <= '0;
         for (int i = 0; i < int'(RX_BUFFER_ENTRIES); i++) begin
            idx_q[i]  <= '0;
            info_q[i] <= '0;
         end
      end else begin
         v_q          <= v_d;
         idx_q        <= idx_d;
         info_q       <= info_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         occ_q        <= occ_d;
         drop_pulse_q <= drop_pulse_d;
         drop_count_q <= drop_count_d;
      end
   end

endmodule

// File: tb/tb_rob_mdp_update_receiver.sv
// Bench for rob_mdp_update_receiver: vector table for basic/full/merge flows, hand sequences for
// kill and reset corners, and a write scoreboard fed at stimulus time.
module tb_rob_mdp_update_receiver;

   logic       CLK;
   logic       RST;
   logic       rob_mdp_update_valid;
   logic [7:0] rob_mdp_update_mdp_info;
   logic [6:0] rob_mdp_update_ROB_index;
   logic [6:0] rob_head_index;
   logic       rob_kill_valid;
   logic [6:0] rob_kill_start_ROB_index;
   logic       rob_mdp_write_valid;
   logic [7:0] rob_mdp_write_mdp_info;
   logic [6:0] rob_mdp_write_ROB_index;
   logic       rob_mdp_write_ready;
   logic       drop_pulse;
   logic [7:0] drop_count;

   rob_mdp_update_receiver dut (
      .CLK                      (CLK),
      .RST                      (RST),
      .rob_mdp_update_valid     (rob_mdp_update_valid),
      .rob_mdp_update_mdp_info  (rob_mdp_update_mdp_info),
      .rob_mdp_update_ROB_index (rob_mdp_update_ROB_index),
      .rob_head_index           (rob_head_index),
      .rob_kill_valid           (rob_kill_valid),
      .rob_kill_start_ROB_index (rob_kill_start_ROB_index),
      .rob_mdp_write_valid      (rob_mdp_write_valid),
      .rob_mdp_write_mdp_info   (rob_mdp_write_mdp_info),
      .rob_mdp_write_ROB_index  (rob_mdp_write_ROB_index),
      .rob_mdp_write_ready      (rob_mdp_write_ready),
      .drop_pulse               (drop_pulse),
      .drop_count               (drop_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic       uv;
      logic [6:0] uidx;
      logic [7:0] uinfo;
      logic       rdy;
      logic       ewv;
      logic [6:0] eidx;
      logic [7:0] einfo;
      logic       edp;
      logic [7:0] edc;
      logic       push;
      logic [7:0] pinfo;
   } vec_t;

   typedef struct {
      logic [6:0] idx;
      logic [7:0] info;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic uv, input logic [6:0] uidx, input logic [7:0] uinfo,
                               input logic rdy, input logic ewv, input logic [6:0] eidx,
                               input logic [7:0] einfo, input logic edp, input logic [7:0] edc,
                               input logic push, input logic [7:0] pinfo);
      vec_t v;
      v = '{uv, uidx, uinfo, rdy, ewv, eidx, einfo, edp, edc, push, pinfo};
      return v;
   endfunction

   task automatic push_exp(input logic [6:0] idx, input logic [7:0] info);
      exp_t e;
      e.idx  = idx;
      e.info = info;
      sb.push_back(e);
   endtask

   task automatic drive(input logic uv, input logic [6:0] uidx, input logic [7:0] uinfo,
                        input logic rdy, input logic kv, input logic [6:0] kidx);
      rob_mdp_update_valid     = uv;
      rob_mdp_update_ROB_index = uidx;
      rob_mdp_update_mdp_info  = uinfo;
      rob_mdp_write_ready      = rdy;
      rob_kill_valid           = kv;
      rob_kill_start_ROB_index = kidx;
   endtask

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_write(input string name, input logic [6:0] idx, input logic [7:0] info);
      chk({name, "_wv"}, 32'(rob_mdp_write_valid), 32'd1);
      chk({name, "_idx"}, 32'(rob_mdp_write_ROB_index), 32'(idx));
      chk({name, "_info"}, 32'(rob_mdp_write_mdp_info), 32'(info));
   endtask

   // Every accepted write is matched against the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (!RST && rob_mdp_write_valid && rob_mdp_write_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_write: got idx=%0d info=%0h, expected no write",
                     rob_mdp_write_ROB_index, rob_mdp_write_mdp_info);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_idx", 32'(rob_mdp_write_ROB_index), 32'(e.idx));
            chk("sb_info", 32'(rob_mdp_write_mdp_info), 32'(e.info));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      RST            = 1'b1;
      rob_head_index = '0;
      drive(1'b0, 7'd0, 8'h00, 1'b0, 1'b0, 7'd0);
      adv();
      adv();
      RST = 1'b0;

      // Basic
      vecs.push_back(mk(0, 7'd0, 8'h00, 1, 0, 7'd0, 8'h00, 0, 8'd0, 0, 8'h00));
      vecs.push_back(mk(1, 7'd5, 8'h81, 1, 0, 7'd0, 8'h00, 0, 8'd0, 1, 8'h81));
      vecs.push_back(mk(0, 7'd0, 8'h00, 1, 1, 7'd5, 8'h81, 0, 8'd0, 0, 8'h00));
      vecs.push_back(mk(0, 7'd0, 8'h00, 1, 0, 7'd0, 8'h00, 0, 8'd0, 0, 8'h00));
      // Full / drop, then full-with-pop accept
      vecs.push_back(mk(1, 7'd1, 8'h11, 0, 0, 7'd0, 8'h00, 0, 8'd0, 1, 8'h11));
      vecs.push_back(mk(1, 7'd2, 8'h12, 0, 1, 7'd1, 8'h11, 0, 8'd0, 1, 8'h12));
      vecs.push_back(mk(1, 7'd3, 8'h13, 0, 1, 7'd1, 8'h11, 0, 8'd0, 1, 8'h13));
      vecs.push_back(mk(1, 7'd4, 8'h14, 0, 1, 7'd1, 8'h11, 0, 8'd0, 1, 8'h14));
      vecs.push_back(mk(1, 7'd5, 8'h15, 0, 1, 7'd1, 8'h11, 0, 8'd0, 0, 8'h00));
      vecs.push_back(mk(0, 7'd0, 8'h00, 0, 1, 7'd1, 8'h11, 1, 8'd1, 0, 8'h00));
      vecs.push_back(mk(1, 7'd6, 8'h16, 1, 1, 7'd1, 8'h11, 0, 8'd1, 1, 8'h16));
      vecs.push_back(mk(0, 7'd0, 8'h00, 1, 1, 7'd2, 8'h12, 0, 8'd1, 0, 8'h00));
      vecs.push_back(mk(0, 7'd0, 8'h00, 1, 1, 7'd3, 8'h13, 0, 8'd1, 0, 8'h00));
      vecs.push_back(mk(0, 7'd0, 8'h00, 1, 1, 7'd4, 8'h14, 0, 8'd1, 0, 8'h00));
      vecs.push_back(mk(0, 7'd0, 8'h00, 1, 1, 7'd6, 8'h16, 0, 8'd1, 0, 8'h00));
      vecs.push_back(mk(0, 7'd0, 8'h00, 1, 0, 7'd0, 8'h00, 0, 8'd1, 0, 8'h00));
      // Merge: first update reserves the slot, the second one's data is what gets written
      vecs.push_back(mk(1, 7'd9, 8'h10, 0, 0, 7'd0, 8'h00, 0, 8'd1, 1, 8'h22));
      vecs.push_back(mk(1, 7'd9, 8'h22, 0, 1, 7'd9, 8'h10, 0, 8'd1, 0, 8'h00));
      vecs.push_back(mk(0, 7'd0, 8'h00, 0, 1, 7'd9, 8'h22, 0, 8'd1, 0, 8'h00));
      vecs.push_back(mk(0, 7'd0, 8'h00, 1, 1, 7'd9, 8'h22, 0, 8'd1, 0, 8'h00));
      vecs.push_back(mk(0, 7'd0, 8'h00, 1, 0, 7'd0, 8'h00, 0, 8'd1, 0, 8'h00));

      foreach (vecs[k]) begin
         drive(vecs[k].uv, vecs[k].uidx, vecs[k].uinfo, vecs[k].rdy, 1'b0, 7'd0);
         if (vecs[k].push) push_exp(vecs[k].uidx, vecs[k].pinfo);
         @(negedge CLK);
         chk($sformatf("vec%0d_wv", k), 32'(rob_mdp_write_valid), 32'(vecs[k].ewv));
         if (vecs[k].ewv) begin
            chk($sformatf("vec%0d_idx", k), 32'(rob_mdp_write_ROB_index), 32'(vecs[k].eidx));
            chk($sformatf("vec%0d_info", k), 32'(rob_mdp_write_mdp_info), 32'(vecs[k].einfo));
         end
         chk($sformatf("vec%0d_drop_pulse", k), 32'(drop_pulse), 32'(vecs[k].edp));
         chk($sformatf("vec%0d_drop_count", k), 32'(drop_count), 32'(vecs[k].edc));
         adv();
      end

      // Kill with ROB-index wrap: head 120, kill from 126 takes 127 and 2 but not 122
      rob_head_index = 7'd120;
      drive(1'b1, 7'd122, 8'hA1, 1'b0, 1'b0, 7'd0);
      push_exp(7'd122, 8'hA1);
      @(negedge CLK);
      chk("kw_first_wv", 32'(rob_mdp_write_valid), 32'd0);
      adv();
      drive(1'b1, 7'd127, 8'hA2, 1'b0, 1'b0, 7'd0);
      @(negedge CLK);
      chk_write("kw_head", 7'd122, 8'hA1);
      adv();
      drive(1'b1, 7'd2, 8'hA3, 1'b0, 1'b0, 7'd0);
      adv();
      drive(1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'd126);
      @(negedge CLK);
      chk_write("kw_kill_cycle", 7'd122, 8'hA1);
      adv();
      drive(1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 7'd0);
      @(negedge CLK);
      chk_write("kw_write", 7'd122, 8'hA1);
      adv();
      for (int c = 0; c < 3; c++) begin
         @(negedge CLK);
         chk($sformatf("kw_hole%0d_wv", c), 32'(rob_mdp_write_valid), 32'd0);
         adv();
      end
      rob_head_index = 7'd0;

      // Same-cycle kill masks the head write and the incoming update
      drive(1'b1, 7'd10, 8'h5A, 1'b0, 1'b0, 7'd0);
      adv();
      drive(1'b1, 7'd12, 8'h77, 1'b1, 1'b1, 7'd10);
      @(negedge CLK);
      chk("sk_masked_wv", 32'(rob_mdp_write_valid), 32'd0);
      adv();
      drive(1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 7'd0);
      @(negedge CLK);
      chk("sk_after_wv", 32'(rob_mdp_write_valid), 32'd0);
      adv();
      drive(1'b1, 7'd20, 8'h3C, 1'b1, 1'b0, 7'd0);
      push_exp(7'd20, 8'h3C);
      @(negedge CLK);
      chk("sk_probe_wv", 32'(rob_mdp_write_valid), 32'd0);
      adv();
      drive(1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 7'd0);
      @(negedge CLK);
      chk_write("sk_probe", 7'd20, 8'h3C);
      adv();
      @(negedge CLK);
      chk("sk_empty_wv", 32'(rob_mdp_write_valid), 32'd0);
      adv();

      // Reset with three buffered entries
      drive(1'b1, 7'd30, 8'hC0, 1'b0, 1'b0, 7'd0);
      adv();
      drive(1'b1, 7'd31, 8'hC1, 1'b0, 1'b0, 7'd0);
      adv();
      drive(1'b1, 7'd32, 8'hC2, 1'b0, 1'b0, 7'd0);
      adv();
      drive(1'b0, 7'd0, 8'h00, 1'b0, 1'b0, 7'd0);
      @(negedge CLK);
      chk_write("rst_pre", 7'd30, 8'hC0);
      adv();
      RST = 1'b1;
      drive(1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 7'd0);
      @(negedge CLK);
      chk("rst_cycle_wv", 32'(rob_mdp_write_valid), 32'd0);
      adv();
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_after_wv", 32'(rob_mdp_write_valid), 32'd0);
      chk("rst_after_drop_count", 32'(drop_count), 32'd0);
      chk("rst_after_drop_pulse", 32'(drop_pulse), 32'd0);
      adv();
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         chk($sformatf("rst_idle%0d_wv", c), 32'(rob_mdp_write_valid), 32'd0);
         adv();
      end

      for (int c = 0; c < 20 && sb.size() != 0; c++) adv();
      chk("sb_outstanding", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
